// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Shares the 56-bit UART TX frame port between three frame producers
// (register reply, ADS1292 data, MPR121 data). Each producer owns a one-frame
// holding slot; a frame is granted by fixed priority (REG first), then
// ADS/MPR round-robin. The block waits for the downstream to finish each
// frame before it issues the next one.
//
// Ports:
//   i_CLK, i_RSTN                   clock, async active-low reset
//   i_<SRC>_DATA/_VALID, o_<SRC>_READY   producer slots (SRC = REG, ADS, MPR)
//   o_UART_DATA_TX/_VALID, i_UART_DATA_TX_READY   downstream frame handshake
//   i_CLR_ERR                       clears o_TX_TIMEOUT (and drop counter)
//   o_TX_TIMEOUT                    sticky timeout flag
//   o_HDR_ERR                       1-cycle pulse when a frame is discarded
//   o_GRANT                         owner: 0 none, 1 REG, 2 ADS, 3 MPR
//   o_BUSY                          arbiter not idle
//   o_DROP_CNT                      only with UART_TX_ARB_DROP_CNT_EN defined:
//                                   saturating count of discards + timeouts
//
// state   | meaning
// ST_IDLE | no frame in flight; pick a winner from the full slots
// ST_REQ  | frame presented with VALID, waiting for downstream acceptance
// ST_WAIT | frame accepted, waiting for downstream to report idle again
module uart_tx_arbiter #(
  parameter int unsigned           TMO_W      = 16,
  parameter logic [TMO_W-1:0]      TMO_CYCLES = 16'd40000
) (
  input  logic        i_CLK,
  input  logic        i_RSTN,
  input  logic [55:0] i_REG_DATA,
  input  logic        i_REG_VALID,
  output logic        o_REG_READY,
  input  logic [55:0] i_ADS_DATA,
  input  logic        i_ADS_VALID,
  output logic        o_ADS_READY,
  input  logic [55:0] i_MPR_DATA,
  input  logic        i_MPR_VALID,
  output logic        o_MPR_READY,
  output logic [55:0] o_UART_DATA_TX,
  output logic        o_UART_DATA_TX_VALID,
  input  logic        i_UART_DATA_TX_READY,
  input  logic        i_CLR_ERR,
  output logic        o_TX_TIMEOUT,
  output logic        o_HDR_ERR,
  output logic [1:0]  o_GRANT,
`ifdef UART_TX_ARB_DROP_CNT_EN
  output logic [7:0]  o_DROP_CNT,
`endif
  output logic        o_BUSY
);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT} state_t;

  state_t             state_q, state_d;
  logic [2:0]         full_q;        // [0] REG, [1] ADS, [2] MPR
  logic [55:0]        reg_data_q, ads_data_q, mpr_data_q;
  logic [55:0]        tx_data_q, tx_data_d;
  logic               tx_valid_q, tx_valid_d;
  logic [1:0]         grant_q, grant_d;
  logic               rr_ads_q, rr_ads_d;  // 1: next ADS/MPR tie goes to ADS
  logic [TMO_W-1:0]   cnt_q, cnt_d;
  logic               first_q, first_d;    // first ST_WAIT cycle
  logic               tmo_q, hdr_err_q;
  logic [2:0]         clr_slot;
  logic               tmo_evt, tmo_hit;
  logic               reg_cap, ads_cap, mpr_cap;
  logic               reg_ok, ads_ok, mpr_ok;
  logic               hdr_evt;

  assign o_REG_READY = ~full_q[0];
  assign o_ADS_READY = ~full_q[1];
  assign o_MPR_READY = ~full_q[2];

  assign reg_cap = i_REG_VALID & ~full_q[0];
  assign ads_cap = i_ADS_VALID & ~full_q[1];
  assign mpr_cap = i_MPR_VALID & ~full_q[2];
  assign reg_ok  = (i_REG_DATA[55:48] == 8'h61) | (i_REG_DATA[55:48] == 8'h6D);
  assign ads_ok  = (i_ADS_DATA[55:48] == 8'hAA);
  assign mpr_ok  = (i_MPR_DATA[55:48] == 8'h6D);
  assign hdr_evt = (reg_cap & ~reg_ok) | (ads_cap & ~ads_ok) | (mpr_cap & ~mpr_ok);

  // Capture and clear never collide: capture needs an empty slot, clear a full one.
  always_ff @(posedge i_CLK or negedge i_RSTN) begin
    if (!i_RSTN) begin
      full_q     <= 3'b000;
      reg_data_q <= '0;
      ads_data_q <= '0;
      mpr_data_q <= '0;
    end else begin
      if (reg_cap && reg_ok) begin
        full_q[0]  <= 1'b1;
        reg_data_q <= i_REG_DATA;
      end else if (clr_slot[0]) begin
        full_q[0]  <= 1'b0;
      end
      if (ads_cap && ads_ok) begin
        full_q[1]  <= 1'b1;
        ads_data_q <= i_ADS_DATA;
      end else if (clr_slot[1]) begin
        full_q[1]  <= 1'b0;
      end
      if (mpr_cap && mpr_ok) begin
        full_q[2]  <= 1'b1;
        mpr_data_q <= i_MPR_DATA;
      end else if (clr_slot[2]) begin
        full_q[2]  <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_CLK or negedge i_RSTN) begin
    if (!i_RSTN) begin
      state_q    <= ST_IDLE;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      grant_q    <= 2'd0;
      rr_ads_q   <= 1'b1;
      cnt_q      <= '0;
      first_q    <= 1'b0;
      tmo_q      <= 1'b0;
      hdr_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      grant_q    <= grant_d;
      rr_ads_q   <= rr_ads_d;
      cnt_q      <= cnt_d;
      first_q    <= first_d;
      hdr_err_q  <= hdr_evt;
      if (tmo_evt)        tmo_q <= 1'b1;
      else if (i_CLR_ERR) tmo_q <= 1'b0;
    end
  end

  // cnt_q counts completed ST_REQ/ST_WAIT cycles, so the abort happens on the
  // TMO_CYCLES-th cycle spent in those states.
  assign tmo_hit = (cnt_q == TMO_CYCLES - 1'b1);

  always_comb begin
    state_d    = state_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    grant_d    = grant_q;
    rr_ads_d   = rr_ads_q;
    cnt_d      = cnt_q;
    first_d    = first_q;
    clr_slot   = 3'b000;
    tmo_evt    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|full_q) begin
          state_d    = ST_REQ;
          tx_valid_d = 1'b1;
          cnt_d      = '0;
          if (full_q[0]) begin
            grant_d   = 2'd1;
            tx_data_d = reg_data_q;
          end else if (full_q[1] && (rr_ads_q || !full_q[2])) begin
            grant_d   = 2'd2;
            tx_data_d = ads_data_q;
            rr_ads_d  = 1'b0;
          end else begin
            grant_d   = 2'd3;
            tx_data_d = mpr_data_q;
            rr_ads_d  = 1'b1;
          end
        end
      end
      ST_REQ: begin
        cnt_d = cnt_q + 1'b1;
        if (i_UART_DATA_TX_READY) begin
          tx_valid_d = 1'b0;
          state_d    = ST_WAIT;
          first_d    = 1'b1;
          case (grant_q)
            2'd1:    clr_slot = 3'b001;
            2'd2:    clr_slot = 3'b010;
            2'd3:    clr_slot = 3'b100;
            default: clr_slot = 3'b000;
          endcase
        end else if (tmo_hit) begin
          // slot kept full; it is retried on the next ST_IDLE decision
          tmo_evt    = 1'b1;
          tx_valid_d = 1'b0;
          grant_d    = 2'd0;
          state_d    = ST_IDLE;
        end
      end
      ST_WAIT: begin
        cnt_d   = cnt_q + 1'b1;
        first_d = 1'b0;
        // ready seen in the first cycle is still the pre-acceptance level
        if (!first_q && i_UART_DATA_TX_READY) begin
          grant_d = 2'd0;
          state_d = ST_IDLE;
        end else if (tmo_hit) begin
          tmo_evt = 1'b1;
          grant_d = 2'd0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign o_UART_DATA_TX       = tx_data_q;
  assign o_UART_DATA_TX_VALID = tx_valid_q;
  assign o_GRANT              = grant_q;
  assign o_TX_TIMEOUT         = tmo_q;
  assign o_HDR_ERR            = hdr_err_q;
  assign o_BUSY               = (state_q != ST_IDLE);

`ifdef UART_TX_ARB_DROP_CNT_EN
  logic [7:0] drop_q;
  logic [8:0] drop_sum;

  assign drop_sum = {1'b0, (i_CLR_ERR ? 8'd0 : drop_q)} + {8'd0, hdr_evt} + {8'd0, tmo_evt};

  always_ff @(posedge i_CLK or negedge i_RSTN) begin
    if (!i_RSTN)          drop_q <= 8'd0;
    else if (drop_sum[8]) drop_q <= 8'hFF;
    else                  drop_q <= drop_sum[7:0];
  end

  assign o_DROP_CNT = drop_q;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;
  localparam int TMO     = 100;
  localparam int DS_BUSY = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [55:0] reg_data = '0, ads_data = '0, mpr_data = '0;
  logic        reg_valid = 1'b0, ads_valid = 1'b0, mpr_valid = 1'b0;
  logic        reg_ready, ads_ready, mpr_ready;
  logic [55:0] tx_data;
  logic        tx_valid;
  logic        ds_ready = 1'b1;
  logic        clr_err = 1'b0;
  logic        tx_tmo, hdr_err, busy;
  logic [1:0]  grant;
`ifdef UART_TX_ARB_DROP_CNT_EN
  logic [7:0]  drop_cnt;
`endif

  always #5 clk = ~clk;

  uart_tx_arbiter #(.TMO_W(16), .TMO_CYCLES(16'd100)) dut (
    .i_CLK(clk), .i_RSTN(rst_n),
    .i_REG_DATA(reg_data), .i_REG_VALID(reg_valid), .o_REG_READY(reg_ready),
    .i_ADS_DATA(ads_data), .i_ADS_VALID(ads_valid), .o_ADS_READY(ads_ready),
    .i_MPR_DATA(mpr_data), .i_MPR_VALID(mpr_valid), .o_MPR_READY(mpr_ready),
    .o_UART_DATA_TX(tx_data), .o_UART_DATA_TX_VALID(tx_valid),
    .i_UART_DATA_TX_READY(ds_ready), .i_CLR_ERR(clr_err),
    .o_TX_TIMEOUT(tx_tmo), .o_HDR_ERR(hdr_err), .o_GRANT(grant),
`ifdef UART_TX_ARB_DROP_CNT_EN
    .o_DROP_CNT(drop_cnt),
`endif
    .o_BUSY(busy)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- downstream UART model ----------------
  logic hold = 1'b0;
  initial begin : ds_model
    int busy_left;
    logic acc;
    busy_left = 0;
    forever begin
      @(negedge clk);
      acc = tx_valid && ds_ready;
      @(posedge clk);
      #1;
      if (acc) busy_left = DS_BUSY;
      else if (busy_left > 0) busy_left--;
      ds_ready = !hold && (busy_left == 0);
    end
  end

  // ---------------- behavioural model + compare ----------------
  logic [55:0] m_data [3];
  bit          m_full [3];
  bit          m_rr_ads;
  int          m_phase;     // 0 idle, 1 presenting, 2 downstream busy
  int          m_owner;
  int          m_used;      // cycles spent on the current grant
  bit          m_first, m_tmo, m_hdr;
  int          m_drop;
  logic        prev_valid = 1'b0;
  int          glog[$];
  logic [55:0] dlog[$];
  int          rise_cnt = 0, hdr_cnt = 0, vhigh_cnt = 0;

  function automatic bit hdr_ok(input int s, input logic [55:0] d);
    logic [7:0] h;
    h = d[55:48];
    if (s == 0) return (h == 8'h61) || (h == 8'h6D);
    if (s == 1) return h == 8'hAA;
    return h == 8'h6D;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin m_full[i] = 0; m_data[i] = '0; end
    m_rr_ads = 1; m_phase = 0; m_owner = 0; m_used = 0;
    m_first = 0; m_tmo = 0; m_hdr = 0; m_drop = 0;
  endtask

  initial model_reset();

  always @(negedge clk) begin : compare
    bit          old_full [3];
    bit          tmo_e, any_bad;
    logic        v [3];
    logic [55:0] d [3];
    if (!rst_n) begin
      check("rst_valid", {63'd0, tx_valid}, 64'd0);
      check("rst_data", {8'd0, tx_data}, 64'd0);
      check("rst_grant", {62'd0, grant}, 64'd0);
      check("rst_busy", {63'd0, busy}, 64'd0);
      check("rst_readies", {61'd0, reg_ready, ads_ready, mpr_ready}, 64'd7);
      check("rst_tmo_hdr", {62'd0, tx_tmo, hdr_err}, 64'd0);
      model_reset();
      prev_valid = 1'b0;
    end else begin
      check("reg_ready", {63'd0, reg_ready}, {63'd0, !m_full[0]});
      check("ads_ready", {63'd0, ads_ready}, {63'd0, !m_full[1]});
      check("mpr_ready", {63'd0, mpr_ready}, {63'd0, !m_full[2]});
      check("tx_valid", {63'd0, tx_valid}, {63'd0, m_phase == 1});
      check("grant", {62'd0, grant}, 64'(m_owner));
      check("busy", {63'd0, busy}, {63'd0, m_phase != 0});
      check("hdr_err", {63'd0, hdr_err}, {63'd0, m_hdr});
      check("tx_timeout", {63'd0, tx_tmo}, {63'd0, m_tmo});
`ifdef UART_TX_ARB_DROP_CNT_EN
      check("drop_cnt", {56'd0, drop_cnt}, 64'(m_drop));
`endif
      if (m_phase == 1) check("tx_data", {8'd0, tx_data}, {8'd0, m_data[m_owner-1]});
      if (tx_valid && !prev_valid) begin
        glog.push_back(int'(grant));
        dlog.push_back(tx_data);
        rise_cnt++;
      end
      if (tx_valid) vhigh_cnt++;
      if (hdr_err) hdr_cnt++;
      prev_valid = tx_valid;

      // advance the model across the coming clock edge
      v[0] = reg_valid; v[1] = ads_valid; v[2] = mpr_valid;
      d[0] = reg_data;  d[1] = ads_data;  d[2] = mpr_data;
      for (int i = 0; i < 3; i++) old_full[i] = m_full[i];
      tmo_e = 0;
      if (m_phase == 0) begin
        if (old_full[0] || old_full[1] || old_full[2]) begin
          if (old_full[0]) m_owner = 1;
          else if (old_full[1] && (m_rr_ads || !old_full[2])) m_owner = 2;
          else m_owner = 3;
          if (m_owner == 2) m_rr_ads = 0;
          if (m_owner == 3) m_rr_ads = 1;
          m_phase = 1;
          m_used = 0;
        end
      end else begin
        m_used++;
        if (m_phase == 1 && ds_ready) begin
          m_full[m_owner-1] = 0;
          m_phase = 2;
          m_first = 1;
        end else if (m_phase == 2 && !m_first && ds_ready) begin
          m_phase = 0; m_owner = 0;
        end else if (m_used == TMO) begin
          tmo_e = 1; m_phase = 0; m_owner = 0;
        end else if (m_phase == 2) begin
          m_first = 0;
        end
      end
      any_bad = 0;
      for (int i = 0; i < 3; i++) begin
        if (v[i] && !old_full[i]) begin
          if (hdr_ok(i, d[i])) begin m_full[i] = 1; m_data[i] = d[i]; end
          else any_bad = 1;
        end
      end
      m_hdr = any_bad;
      m_drop = (clr_err ? 0 : m_drop) + int'(any_bad) + int'(tmo_e);
      if (m_drop > 255) m_drop = 255;
      if (tmo_e) m_tmo = 1;
      else if (clr_err) m_tmo = 0;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input int s, input logic [55:0] dat, input logic vv);
    case (s)
      0: begin reg_data = dat; reg_valid = vv; end
      1: begin ads_data = dat; ads_valid = vv; end
      default: begin mpr_data = dat; mpr_valid = vv; end
    endcase
  endtask

  task automatic push(input int mask, input logic [55:0] d0, input logic [55:0] d1, input logic [55:0] d2);
    int n;
    @(posedge clk); #1;
    if (mask[0]) drive(0, d0, 1'b1);
    if (mask[1]) drive(1, d1, 1'b1);
    if (mask[2]) drive(2, d2, 1'b1);
    n = 0;
    do begin
      @(negedge clk); n++;
    end while (((mask[0] && !reg_ready) || (mask[1] && !ads_ready) || (mask[2] && !mpr_ready)) && n < 2000);
    if (n >= 2000) check("push_ready_wait", 64'(n), 64'd0);
    @(posedge clk); #1;
    reg_valid = 1'b0; ads_valid = 1'b0; mpr_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk); n++;
    end while ((busy || !reg_ready || !ads_ready || !mpr_ready) && n < 5000);
    if (n >= 5000) check("wait_idle_bound", 64'(n), 64'd0);
  endtask

  task automatic clear_logs();
    glog.delete(); dlog.delete();
    rise_cnt = 0; hdr_cnt = 0; vhigh_cnt = 0;
  endtask

  localparam logic [55:0] F_REG = 56'h61_0005_000000_00;
  localparam logic [55:0] F_ADS = 56'hAA_112233_445566;
  localparam logic [55:0] F_MPR = 56'h6D_00AB_000000_00;

  initial begin : stim
    int exp_alt [8];
    int n;
    exp_alt = '{2, 3, 2, 3, 2, 3, 2, 3};
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // single REG frame
    clear_logs();
    push(1, F_REG, '0, '0);
    wait_idle();
    check("reg_grant_count", 64'(glog.size()), 64'd1);
    if (glog.size() >= 1) begin
      check("reg_grant", 64'(glog[0]), 64'd1);
      check("reg_frame", {8'd0, dlog[0]}, {8'd0, F_REG});
    end
    check("reg_valid_cycles", 64'(vhigh_cnt), 64'd1);

    // ADS and MPR both pending, four rounds
    clear_logs();
    for (int r = 0; r < 4; r++) begin
      push(6, '0, F_ADS, F_MPR);
      wait_idle();
    end
    check("rr_count", 64'(glog.size()), 64'd8);
    for (int i = 0; i < 8 && i < glog.size(); i++)
      check($sformatf("rr_grant_%0d", i), 64'(glog[i]), 64'(exp_alt[i]));

    // all three pending
    clear_logs();
    push(7, F_REG, F_ADS, F_MPR);
    wait_idle();
    check("all3_count", 64'(glog.size()), 64'd3);
    if (glog.size() == 3) begin
      check("all3_first", 64'(glog[0]), 64'd1);
      check("all3_second", 64'(glog[1]), 64'd2);
      check("all3_third", 64'(glog[2]), 64'd3);
      check("all3_mpr_data", {8'd0, dlog[2]}, {8'd0, F_MPR});
    end

    // bad ADS header
    clear_logs();
    push(2, '0, 56'hBB_112233_445566, '0);
    repeat (5) @(negedge clk);
    check("badhdr_pulses", 64'(hdr_cnt), 64'd1);
    check("badhdr_no_valid", 64'(rise_cnt), 64'd0);
    check("badhdr_ads_ready", {63'd0, ads_ready}, 64'd1);
`ifdef UART_TX_ARB_DROP_CNT_EN
    check("badhdr_drop_cnt", {56'd0, drop_cnt}, 64'd1);
`endif

    // timeout with downstream stalled
    clear_logs();
    @(posedge clk); #1 hold = 1'b1;
    repeat (3) @(posedge clk);
    push(1, 56'h6D_0010_000000_00, '0, '0);
    n = 0;
    while (!tx_valid && n < 50) begin @(negedge clk); n++; end
    check("tmo_valid_seen", {63'd0, tx_valid}, 64'd1);
    n = 0;
    while (!tx_tmo && n < 500) begin @(negedge clk); n++; end
    check("tmo_cycle", 64'(n), 64'd100);
    check("tmo_slot_full", {63'd0, reg_ready}, 64'd0);
    @(posedge clk); #1 hold = 1'b0;
    wait_idle();
    check("tmo_regrant_count", 64'(glog.size()), 64'd2);
    if (glog.size() == 2) check("tmo_regrant", 64'(glog[1]), 64'd1);
    check("tmo_sticky", {63'd0, tx_tmo}, 64'd1);
    @(posedge clk); #1 clr_err = 1'b1;
    @(posedge clk); #1 clr_err = 1'b0;
    @(negedge clk);
    check("tmo_cleared", {63'd0, tx_tmo}, 64'd0);

    // reset asserted while a frame is in ST_WAIT and MPR is queued
    clear_logs();
    push(6, '0, F_ADS, F_MPR);
    n = 0;
    while (!tx_valid && n < 50) begin @(negedge clk); n++; end
    check("rstw_ads_grant", {62'd0, grant}, 64'd2);
    @(posedge clk);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("rstw_async_valid", {63'd0, tx_valid}, 64'd0);
    check("rstw_async_grant", {62'd0, grant}, 64'd0);
    check("rstw_async_busy", {63'd0, busy}, 64'd0);
    check("rstw_async_readies", {61'd0, reg_ready, ads_ready, mpr_ready}, 64'd7);
    @(posedge clk); #1 rst_n = 1'b1;
    wait_idle();
    clear_logs();
    push(6, '0, F_ADS, F_MPR);
    wait_idle();
    check("rstw_rr_count", 64'(glog.size()), 64'd2);
    if (glog.size() == 2) begin
      check("rstw_rr_first", 64'(glog[0]), 64'd2);
      check("rstw_rr_second", 64'(glog[1]), 64'd3);
    end

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares the single 56-bit UART TX frame port of uart_controller between three frame producers: the register-read reply path, the ADS1292 data path and the MPR121 data path. Each producer gets a one-frame holding slot. Frames are granted by priority plus round-robin and forwarded over a valid/ready handshake. The block waits for the downstream to finish each frame before issuing the next. It sits between the sensor/core logic and uart_controller (i_UART_DATA_TX / i_UART_DATA_TX_VALID / o_UART_DATA_TX_READY).

Parameters:
TMO_CYCLES, 16'd40000, max cycles in ST_REQ+ST_WAIT before timeout (7-byte frame at 25 MHz/115200 is ~15190 cycles)
TMO_W, 16, timeout counter width

Ports:
i_CLK  in  1  system clock
i_RSTN  in  1  asynchronous active-low reset
i_REG_DATA  in  56  register reply frame, header [55:48]
i_REG_VALID  in  1  REG frame valid
o_REG_READY  out  1  REG slot empty
i_ADS_DATA  in  56  ADS data frame
i_ADS_VALID  in  1  ADS frame valid
o_ADS_READY  out  1  ADS slot empty
i_MPR_DATA  in  56  MPR data frame
i_MPR_VALID  in  1  MPR frame valid
o_MPR_READY  out  1  MPR slot empty
o_UART_DATA_TX  out  56  frame to uart_controller
o_UART_DATA_TX_VALID  out  1  frame valid to uart_controller
i_UART_DATA_TX_READY  in  1  uart_controller idle/ready
i_CLR_ERR  in  1  clears o_TX_TIMEOUT
o_TX_TIMEOUT  out  1  sticky timeout flag
o_HDR_ERR  out  1  1-cycle pulse on discarded frame
o_GRANT  out  2  current owner: 0 none, 1 REG, 2 ADS, 3 MPR
o_BUSY  out  1  state != ST_IDLE

Behaviour:
- Async reset (i_RSTN=0):
  - all slots empty; state ST_IDLE.
  - o_UART_DATA_TX=0, o_UART_DATA_TX_VALID=0, o_TX_TIMEOUT=0, o_HDR_ERR=0, o_GRANT=0, o_BUSY=0.
  - round-robin pointer = ADS (next grant between ADS/MPR goes to ADS).
  - Reset mid-frame abandons the frame with no flush.
- Slot ready:
  - o_x_READY = ~slot_full (combinational), so it is 1 in reset.
  - Capture on valid&&ready at the clock edge; the slot is full from the next cycle.
  - A slot is cleared only on downstream acceptance.
- Header check at capture:
  - REG accepts 8'h61 or 8'h6D.
  - ADS accepts 8'hAA.
  - MPR accepts 8'h6D.
  - Any other header: handshake completes, frame discarded, slot stays empty, o_HDR_ERR=1 the next cycle for 1 cycle.
- FSM:
  - ST_IDLE: if any slot is full, pick a winner: REG always first; otherwise ADS/MPR by round-robin pointer; the pointer flips to the other source after each ADS/MPR grant. Load o_UART_DATA_TX, set o_GRANT, clear timeout counter, go ST_REQ. Grant decision takes 1 cycle.
  - ST_REQ: o_UART_DATA_TX_VALID=1, data stable. On i_UART_DATA_TX_READY=1 at an edge: transfer; VALID<=0, clear granted slot, go ST_WAIT.
  - ST_WAIT: ignore ready in the first cycle (downstream drops ready the cycle after acceptance). Afterwards, ready=1 means the frame is done: o_GRANT<=0, go ST_IDLE.
- Timeout counter increments every cycle in ST_REQ/ST_WAIT. At TMO_CYCLES:
  - o_TX_TIMEOUT<=1, VALID<=0, go ST_IDLE.
  - In ST_REQ the slot is retained and retried later.
  - In ST_WAIT the frame is considered lost.
- i_CLR_ERR clears o_TX_TIMEOUT; a same-cycle new timeout wins.
- Simultaneous capture into a slot and grant of another slot is allowed. A slot captured in the same cycle as an ST_IDLE decision is not seen until the next ST_IDLE cycle.
- Minimum back-to-back spacing: ST_IDLE(1) + ST_REQ(>=1) + ST_WAIT(>=2) cycles.

Optional Feature:
- UART_TX_ARB_DROP_CNT_EN defined: adds output o_DROP_CNT[7:0], reset 0, saturating at 8'hFF.
  - Increments once per header discard and once per timeout.
  - If both happen in the same cycle it increments by 2, saturating.
  - i_CLR_ERR clears it.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- REG frame 56'h61_0005_000000_00 with downstream ready=1 → VALID high 1 cycle, o_UART_DATA_TX equals the frame, o_GRANT=1, o_REG_READY back to 1 after accept.
- ADS 56'hAA_112233_445566 and MPR 56'h6D_00AB_000000_00 both pending, repeated 4 times → grants alternate ADS,MPR,ADS,MPR,… starting with ADS after reset.
- REG, ADS, MPR all pending simultaneously → REG granted first, then ADS, then MPR.
- ADS frame with header 8'hBB → o_ADS_READY stays 1, o_HDR_ERR pulses 1 cycle, no VALID; o_DROP_CNT=1 when the macro is defined.
- Downstream ready held 0 for TMO_CYCLES=100 (override) → o_TX_TIMEOUT=1 at cycle 100, slot still full, regranted after ready returns; i_CLR_ERR clears the flag.
- i_RSTN pulsed low during ST_WAIT → all outputs return to reset values asynchronously, slots empty, readies 1.
